vectored_interrupt_controller: RTL and testbench
================================================

// Module: vectored_interrupt_controller
// PURPOSE
//  Parametrised, prioritised, vectored interrupt controller for the SOC core. Collects NUM_IRQ sources
//  (vblank, illegal opcode, future peripherals), latches them per-channel in edge or level mode with
//  masking, and presents one request plus vector address to the hazard control unit via a req/ack/done
//  handshake. Sits between peripherals/datapath and hazard_control_unit; config written from the SFR file.
// PARAMETERS
//  NUM_IRQ     8        number of interrupt sources, 2..32; ID_W = $clog2(NUM_IRQ) (localparam)
//  VEC_WIDTH   14       width of vector address (program counter width)
//  VEC_BASE    14'h0010 vector address of channel 0
//  VEC_STRIDE  4        address distance between consecutive channel vectors
// PORTS
//  clock        in   1          core clock
//  reset        in   1          synchronous, active-high reset
//  irq_in       in   NUM_IRQ    raw interrupt lines, synchronous to clock
//  cfg_wen      in   1          config register write strobe
//  cfg_addr     in   2          0 = enable mask, 1 = mode (1 = edge, 0 = level), 2 = W1C pending, 3 = global enable (bit0)
//  cfg_wdata    in   NUM_IRQ    config write data
//  int_ack      in   1          hazard unit accepted the request (1-cycle pulse)
//  int_done     in   1          ISR return retired (1-cycle pulse)
//  interrupt    out  1          request to hazard unit
//  int_vec_addr out  VEC_WIDTH  vector of the request being presented/serviced
//  int_id       out  ID_W       channel number of the request being presented/serviced
//  in_service   out  1          an ISR is executing
//  pending      out  NUM_IRQ    pending bits (unmasked)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, enable mask 0, mode 0 (level), global enable 0, pending 0, irq_prev 0.
//  Pending: edge channel sets on irq_in=1 & irq_prev=0 (irq_prev = irq_in delayed 1 cycle); set visible
//   next cycle; cleared by W1C write or by int_ack for that channel; set wins over clear in same cycle.
//   Level channel: pending = irq_in registered each cycle; W1C and ack have no effect.
//  Eligible = pending & enable mask & {NUM_IRQ{global_en}}; lowest index = highest priority.
//  Config writes take effect next cycle; cfg_wdata bits above NUM_IRQ ignored; cfg_addr 3 uses bit0 only.
//  FSM:
//   IDLE    -> REQ when any eligible: latch winner into int_id, int_vec_addr = VEC_BASE + int_id*VEC_STRIDE
//              truncated to VEC_WIDTH (wraps modulo 2^VEC_WIDTH); interrupt=1 from next cycle.
//   REQ     interrupt, int_id, int_vec_addr held stable; a higher-priority arrival or masking does NOT
//           change or withdraw the request. On int_ack -> SERVICE: interrupt=0 next cycle, edge pending bit of
//           int_id cleared, in_service=1.
//   SERVICE no new request (no nesting). On int_done -> IDLE, in_service=0; arbitration resumes in IDLE,
//           so earliest next interrupt=1 is 2 cycles after int_done.
//  int_ack outside REQ ignored; int_done outside SERVICE ignored; int_ack and int_done same cycle in REQ:
//   ack handled, done ignored.
//  Level source still high after ISR re-requests; ISR must quiet the source.
//  Reset mid-operation (any state) returns to IDLE with all state cleared in the next cycle.
//  Latency: edge on irq_in (cycle 0) -> pending (cycle 1) -> interrupt=1 (cycle 2) when IDLE and enabled.
// TESTING
//  1 Reset, enable=8'hFF, global=1, edge mode ch3, pulse irq_in[3] at cycle 0 -> interrupt=1 at cycle 2,
//    int_id=3, int_vec_addr=14'h001C; ack -> interrupt=0, pending[3]=0, in_service=1.
//  2 Edges on ch5 and ch1 same cycle -> ch1 served first (vec 14'h0014); after done, ch5 requested (14'h0024).
//  3 During REQ for ch4, raise ch0 -> int_id stays 4 until ack; ch0 served after int_done.
//  4 Mask ch2 (enable=8'hFB), edge ch2 -> pending[2]=1, interrupt stays 0; enable ch2 -> interrupt 2 cycles later.
//  5 Level ch6 held high across ack/done -> re-requested 2 cycles after int_done; W1C on ch6 no effect.
//  6 Assert reset while in SERVICE -> next cycle interrupt=0, in_service=0, pending=0, mask=0; spurious
//    int_ack/int_done in IDLE leave state unchanged.

Source files
------------

// File: rtl/vectored_interrupt_controller.sv
// Prioritised, vectored interrupt controller.
// Collects NUM_IRQ sources, latches them per channel in edge or level mode,
// applies a per-channel enable mask plus a global enable, and presents one
// request (channel id + vector address) to the hazard unit through a
// req / ack / done handshake. No nesting: a new request is only raised from
// IDLE, after the previous ISR has reported done.
module vectored_interrupt_controller #(
    parameter int                   NUM_IRQ    = 8,
    parameter int                   VEC_WIDTH  = 14,
    parameter logic [VEC_WIDTH-1:0] VEC_BASE   = 14'h0010,
    parameter int                   VEC_STRIDE = 4,
    localparam int                  ID_W       = $clog2(NUM_IRQ)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_IRQ-1:0]   irq_in,
    input  logic                 cfg_wen,
    input  logic [1:0]           cfg_addr,
    input  logic [NUM_IRQ-1:0]   cfg_wdata,
    input  logic                 int_ack,
    input  logic                 int_done,
    output logic                 interrupt,
    output logic [VEC_WIDTH-1:0] int_vec_addr,
    output logic [ID_W-1:0]      int_id,
    output logic                 in_service,
    output logic [NUM_IRQ-1:0]   pending
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam logic [NUM_IRQ-1:0] ONE_HOT_LSB = {{(NUM_IRQ-1){1'b0}}, 1'b1};

    state_t               state_r;
    state_t               state_next_s;
    logic [NUM_IRQ-1:0]   enable_r;
    logic [NUM_IRQ-1:0]   mode_r;
    logic                 global_en_r;
    logic [NUM_IRQ-1:0]   pending_r;
    logic [NUM_IRQ-1:0]   irq_prev_r;
    logic [ID_W-1:0]      id_r;
    logic [VEC_WIDTH-1:0] vec_r;
    logic                 interrupt_r;
    logic                 in_service_r;

    logic [NUM_IRQ-1:0]   eligible_s;
    logic [ID_W-1:0]      winner_s;
    logic                 latch_s;
    logic                 ack_take_s;
    logic [NUM_IRQ-1:0]   w1c_s;
    logic [NUM_IRQ-1:0]   ack_clr_s;
    logic [NUM_IRQ-1:0]   edge_next_s;
    logic [NUM_IRQ-1:0]   pending_next_s;

    // Lowest set index wins (channel 0 has the highest priority).
    function automatic logic [ID_W-1:0] first_set(input logic [NUM_IRQ-1:0] vec);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = ID_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Vector address of a channel; the sum wraps modulo 2^VEC_WIDTH (VEC_WIDTH <= 32).
    function automatic logic [VEC_WIDTH-1:0] vec_of(input logic [ID_W-1:0] id);
        logic [31:0] full;
        full = 32'(VEC_BASE) + (32'(id) * 32'(VEC_STRIDE));
        return full[VEC_WIDTH-1:0];
    endfunction

    // Arbitration: eligible sources and the winning channel.
    always_comb begin
        eligible_s = pending_r & enable_r & {NUM_IRQ{global_en_r}};
        winner_s   = first_set(eligible_s);
    end

    // Handshake FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        latch_s      = 1'b0;
        ack_take_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (|eligible_s) begin
                    state_next_s = ST_REQ;
                    latch_s      = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                // Done in the same cycle as ack is ignored: only ack moves us on.
                if (int_ack) begin
                    state_next_s = ST_SERVICE;
                    ack_take_s   = 1'b1;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_SERVICE: begin
                if (int_done) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_SERVICE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Pending update: edge channels set on rising edge (set beats clear), level channels track irq_in.
    always_comb begin
        if (cfg_wen && (cfg_addr == 2'd2)) begin
            w1c_s = cfg_wdata;
        end else begin
            w1c_s = '0;
        end
        if (ack_take_s) begin
            ack_clr_s = ONE_HOT_LSB << id_r;
        end else begin
            ack_clr_s = '0;
        end
        edge_next_s    = (pending_r & ~(w1c_s | ack_clr_s)) | (irq_in & ~irq_prev_r);
        pending_next_s = (mode_r & edge_next_s) | (~mode_r & irq_in);
    end

    // Configuration registers written from the SFR file.
    always_ff @(posedge clock) begin
        if (reset) begin
            enable_r    <= '0;
            mode_r      <= '0;
            global_en_r <= 1'b0;
        end else if (cfg_wen) begin
            case (cfg_addr)
                2'd0:    enable_r    <= cfg_wdata;
                2'd1:    mode_r      <= cfg_wdata;
                2'd3:    global_en_r <= cfg_wdata[0];
                default: begin end
            endcase
        end
    end

    // FSM state, pending bits and registered handshake outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            irq_prev_r   <= '0;
            pending_r    <= '0;
            id_r         <= '0;
            vec_r        <= '0;
            interrupt_r  <= 1'b0;
            in_service_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            irq_prev_r   <= irq_in;
            pending_r    <= pending_next_s;
            interrupt_r  <= (state_next_s == ST_REQ);
            in_service_r <= (state_next_s == ST_SERVICE);
            if (latch_s) begin
                id_r  <= winner_s;
                vec_r <= vec_of(winner_s);
            end
        end
    end

    assign interrupt    = interrupt_r;
    assign int_vec_addr = vec_r;
    assign int_id       = id_r;
    assign in_service   = in_service_r;
    assign pending      = pending_r;

endmodule

// File: tb/tb_vectored_interrupt_controller.sv
// Directed bench for vectored_interrupt_controller (NUM_IRQ=8, VEC_BASE=0x10, stride 4).
module tb_vectored_interrupt_controller;

    localparam int N = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic [N-1:0]  irq_in;
    logic          cfg_wen;
    logic [1:0]    cfg_addr;
    logic [N-1:0]  cfg_wdata;
    logic          int_ack;
    logic          int_done;
    logic          interrupt;
    logic [13:0]   int_vec_addr;
    logic [2:0]    int_id;
    logic          in_service;
    logic [N-1:0]  pending;

    int checks   = 0;
    int failures = 0;

    vectored_interrupt_controller #(
        .NUM_IRQ    (8),
        .VEC_WIDTH  (14),
        .VEC_BASE   (14'h0010),
        .VEC_STRIDE (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .irq_in       (irq_in),
        .cfg_wen      (cfg_wen),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .int_ack      (int_ack),
        .int_done     (int_done),
        .interrupt    (interrupt),
        .int_vec_addr (int_vec_addr),
        .int_id       (int_id),
        .in_service   (in_service),
        .pending      (pending)
    );

    // Free-running core clock.
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [N-1:0] data);
        cfg_wen   = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
        tick();
        cfg_wen   = 1'b0;
        cfg_wdata = '0;
    endtask

    task automatic pulse(input logic [N-1:0] mask);
        irq_in = mask;
        tick();
        irq_in = '0;
    endtask

    task automatic do_ack();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    task automatic do_done();
        int_done = 1'b1;
        tick();
        int_done = 1'b0;
    endtask

    // Stop a runaway simulation.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus with hand-computed expectations.
    initial begin
        reset = 1'b1; irq_in = '0; cfg_wen = 1'b0; cfg_addr = 2'd0;
        cfg_wdata = '0; int_ack = 1'b0; int_done = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_eq("rst_interrupt",  32'(interrupt),    32'h0);
        check_eq("rst_in_service", 32'(in_service),   32'h0);
        check_eq("rst_pending",    32'(pending),      32'h0);
        check_eq("rst_id",         32'(int_id),       32'h0);
        check_eq("rst_vec",        32'(int_vec_addr), 32'h0);

        // 1: edge ch3, latency 2 cycles, vector 0x1C, ack clears pending
        cfg_write(2'd0, 8'hFF);
        cfg_write(2'd1, 8'h08);
        cfg_write(2'd3, 8'h01);
        pulse(8'h08);
        check_eq("t1_pend_c1",     32'(pending),      32'h08);
        check_eq("t1_int_c1",      32'(interrupt),    32'h0);
        tick();
        check_eq("t1_int_c2",      32'(interrupt),    32'h1);
        check_eq("t1_id",          32'(int_id),       32'h3);
        check_eq("t1_vec",         32'(int_vec_addr), 32'h001C);
        do_ack();
        check_eq("t1_int_ack",     32'(interrupt),    32'h0);
        check_eq("t1_pend_ack",    32'(pending),      32'h00);
        check_eq("t1_insvc",       32'(in_service),   32'h1);
        do_done();
        check_eq("t1_insvc_done",  32'(in_service),   32'h0);

        // 2: simultaneous ch5 + ch1 edges, ch1 first
        cfg_write(2'd1, 8'hFF);
        pulse(8'h22);
        tick();
        check_eq("t2_id_first",    32'(int_id),       32'h1);
        check_eq("t2_vec_first",   32'(int_vec_addr), 32'h0014);
        do_ack();
        check_eq("t2_pend_left",   32'(pending),      32'h20);
        do_done();
        check_eq("t2_int_gap",     32'(interrupt),    32'h0);
        tick();
        check_eq("t2_int_second",  32'(interrupt),    32'h1);
        check_eq("t2_id_second",   32'(int_id),       32'h5);
        check_eq("t2_vec_second",  32'(int_vec_addr), 32'h0024);
        do_ack();
        do_done();

        // 3: higher-priority arrival during REQ does not preempt
        pulse(8'h10);
        tick();
        check_eq("t3_id_req",      32'(int_id),       32'h4);
        pulse(8'h01);
        check_eq("t3_pend_both",   32'(pending),      32'h11);
        check_eq("t3_id_held",     32'(int_id),       32'h4);
        tick();
        check_eq("t3_id_held2",    32'(int_id),       32'h4);
        check_eq("t3_vec_held",    32'(int_vec_addr), 32'h0020);
        do_ack();
        check_eq("t3_pend_ack",    32'(pending),      32'h01);
        do_done();
        tick();
        check_eq("t3_id_next",     32'(int_id),       32'h0);
        check_eq("t3_vec_next",    32'(int_vec_addr), 32'h0010);
        do_ack();
        do_done();

        // 4: masked ch2 stays pending without a request until enabled
        cfg_write(2'd0, 8'hFB);
        pulse(8'h04);
        check_eq("t4_pend",        32'(pending),      32'h04);
        tick();
        check_eq("t4_int_masked",  32'(interrupt),    32'h0);
        cfg_write(2'd0, 8'hFF);
        check_eq("t4_int_c1",      32'(interrupt),    32'h0);
        tick();
        check_eq("t4_int_c2",      32'(interrupt),    32'h1);
        check_eq("t4_vec",         32'(int_vec_addr), 32'h0018);
        do_ack();
        do_done();

        // 5: level ch6 held high re-requests; W1C has no effect
        cfg_write(2'd1, 8'hBF);
        irq_in = 8'h40;
        tick();
        check_eq("t5_pend_lvl",    32'(pending),      32'h40);
        tick();
        check_eq("t5_id",          32'(int_id),       32'h6);
        check_eq("t5_vec",         32'(int_vec_addr), 32'h0028);
        cfg_write(2'd2, 8'h40);
        check_eq("t5_pend_w1c",    32'(pending),      32'h40);
        check_eq("t5_int_w1c",     32'(interrupt),    32'h1);
        do_ack();
        check_eq("t5_pend_ack",    32'(pending),      32'h40);
        do_done();
        check_eq("t5_int_gap",     32'(interrupt),    32'h0);
        tick();
        check_eq("t5_int_rereq",   32'(interrupt),    32'h1);
        check_eq("t5_id_rereq",    32'(int_id),       32'h6);
        irq_in = '0;
        tick();
        check_eq("t5_pend_quiet",  32'(pending),      32'h00);
        do_ack();
        do_done();
        tick();
        check_eq("t5_int_idle",    32'(interrupt),    32'h0);

        // 7: ack and done together in REQ: ack taken, done ignored
        pulse(8'h08);
        tick();
        int_ack = 1'b1; int_done = 1'b1;
        tick();
        int_ack = 1'b0; int_done = 1'b0;
        check_eq("t7_insvc",       32'(in_service),   32'h1);
        do_done();
        check_eq("t7_insvc_done",  32'(in_service),   32'h0);

        // 6: reset in SERVICE clears everything; spurious ack/done in IDLE ignored
        pulse(8'h0A);
        tick();
        check_eq("t6_id",          32'(int_id),       32'h1);
        do_ack();
        check_eq("t6_insvc",       32'(in_service),   32'h1);
        check_eq("t6_pend",        32'(pending),      32'h08);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("t6_rst_int",     32'(interrupt),    32'h0);
        check_eq("t6_rst_insvc",   32'(in_service),   32'h0);
        check_eq("t6_rst_pend",    32'(pending),      32'h00);
        check_eq("t6_rst_id",      32'(int_id),       32'h0);
        irq_in = 8'h01;
        tick();
        tick();
        check_eq("t6_lvl_pend",    32'(pending),      32'h01);
        check_eq("t6_mask_int",    32'(interrupt),    32'h0);
        irq_in = '0;
        do_ack();
        check_eq("t6_spur_ack_i",  32'(interrupt),    32'h0);
        check_eq("t6_spur_ack_s",  32'(in_service),   32'h0);
        do_done();
        check_eq("t6_spur_done_i", 32'(interrupt),    32'h0);
        check_eq("t6_spur_done_s", 32'(in_service),   32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
